// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the multi-block AES decryption controller.
package aes_ctrl_pkg;

    localparam int AES_BLOCK_W            = 128;
    localparam int DEFAULT_NUM_BLOCKS     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 8;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LOAD,
        ST_COMPUTE,
        ST_STORE,
        ST_READY,
        ST_ERROR
    } ctrl_state_e;

endpackage

// File: rtl/aes_timeout_counter.sv
// Saturating cycle counter that flags when a core run has used its full budget.
module aes_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at the last budgeted value instead of wrapping back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/aes_multi_controller.sv
// Sequences an external AES decryption core over NUM_BLOCKS ciphertext blocks,
// collecting each plaintext block and flagging completion or core timeout.
module aes_multi_controller
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_BLOCKS     = DEFAULT_NUM_BLOCKS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              io_ready,
    input  logic [AES_BLOCK_W*NUM_BLOCKS-1:0] msg_en,
    input  logic [AES_BLOCK_W-1:0]            key,
    output logic [AES_BLOCK_W*NUM_BLOCKS-1:0] msg_de,
    output logic                              aes_ready,
    output logic                              aes_error,
    output logic [3:0]                        block_idx,
    output logic                              core_run,
    output logic [AES_BLOCK_W-1:0]            core_msg_en,
    output logic [AES_BLOCK_W-1:0]            core_key,
    input  logic [AES_BLOCK_W-1:0]            core_msg_de,
    input  logic                              core_ready
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_BLOCKS - 1);

    ctrl_state_e state_q;
    logic [3:0]  block_idx_q;
    logic        core_run_q;
    logic        aes_ready_q;
    logic        aes_error_q;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_expired;
    logic store_en;

    assign store_en = (state_q == ST_COMPUTE) && core_ready;
    assign cnt_clr  = (state_q == ST_WAIT) || (state_q == ST_STORE);
    assign cnt_en   = (state_q == ST_COMPUTE);

    aes_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    // core_ready is tested before the timeout so a last-cycle completion still stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            block_idx_q <= '0;
            core_run_q  <= 1'b0;
            aes_ready_q <= 1'b0;
            aes_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (io_ready) begin
                        state_q     <= ST_LOAD;
                        block_idx_q <= '0;
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_COMPUTE;
                    core_run_q <= 1'b1;
                end
                ST_COMPUTE: begin
                    if (core_ready) begin
                        state_q    <= ST_STORE;
                        core_run_q <= 1'b0;
                    end else if (cnt_expired) begin
                        state_q     <= ST_ERROR;
                        core_run_q  <= 1'b0;
                        aes_error_q <= 1'b1;
                    end
                end
                ST_STORE: begin
                    if (block_idx_q == LAST_IDX) begin
                        state_q     <= ST_READY;
                        aes_ready_q <= 1'b1;
                    end else begin
                        state_q     <= ST_LOAD;
                        block_idx_q <= block_idx_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (!io_ready) begin
                        state_q     <= ST_WAIT;
                        aes_ready_q <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (!io_ready) begin
                        state_q     <= ST_WAIT;
                        aes_error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_WAIT;
                    core_run_q  <= 1'b0;
                    aes_ready_q <= 1'b0;
                    aes_error_q <= 1'b0;
                end
            endcase
        end
    end

    // One result register per block; only the slot being processed is written.
    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_slot
        logic [AES_BLOCK_W-1:0] slot_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_q <= '0;
            end else if (store_en && (block_idx_q == 4'(gi))) begin
                slot_q <= core_msg_de;
            end
        end

        assign msg_de[AES_BLOCK_W*gi +: AES_BLOCK_W] = slot_q;
    end

    assign core_msg_en = msg_en[AES_BLOCK_W*block_idx_q +: AES_BLOCK_W];
    assign core_key    = key;
    assign block_idx   = block_idx_q;
    assign core_run    = core_run_q;
    assign aes_ready   = aes_ready_q;
    assign aes_error   = aes_error_q;

endmodule

// File: tb/tb_aes_multi_controller.sv
// Directed bench for aes_multi_controller with a latency-programmable AES core stand-in.
module tb_aes_multi_controller;

    localparam int NB = 2;
    localparam int TO = 16;
    localparam int CW = 8;
    localparam int W  = 128;

    localparam logic [W-1:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [W-1:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] B1  = 128'hdeadbeef0123456789abcdeffedcba98;

    logic            clk;
    logic            reset;
    logic            io_ready;
    logic [W*NB-1:0] msg_en;
    logic [W-1:0]    key;
    logic [W*NB-1:0] msg_de;
    logic            aes_ready;
    logic            aes_error;
    logic [3:0]      block_idx;
    logic            core_run;
    logic [W-1:0]    core_msg_en;
    logic [W-1:0]    core_key;
    logic [W-1:0]    core_msg_de;
    logic            core_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // Core stand-in: ready on the ready_delay-th run cycle (0 = never), never for hang_blk.
    int run_cnt     = 0;
    int ready_delay = 5;
    int hang_blk    = -1;

    aes_multi_controller #(
        .NUM_BLOCKS     (NB),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_ready    (io_ready),
        .msg_en      (msg_en),
        .key         (key),
        .msg_de      (msg_de),
        .aes_ready   (aes_ready),
        .aes_error   (aes_error),
        .block_idx   (block_idx),
        .core_run    (core_run),
        .core_msg_en (core_msg_en),
        .core_key    (core_key),
        .core_msg_de (core_msg_de),
        .core_ready  (core_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!core_run) run_cnt <= 0;
        else           run_cnt <= run_cnt + 1;
    end

    assign core_ready  = core_run && (ready_delay != 0) && (run_cnt == ready_delay - 1)
                         && (int'(block_idx) != hang_blk);
    assign core_msg_de = (core_msg_en == CT && core_key == KEY) ? PT : (core_msg_en ^ core_key);

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        io_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Cycles are counted from the first edge after the call; stops on ready or error.
    task automatic wait_done(input string tag, output int cyc, output int run_cyc);
        cyc     = 0;
        run_cyc = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (core_run) run_cyc++;
            if (aes_ready || aes_error) break;
        end
        check({tag, "_done"}, 256'(aes_ready | aes_error), 256'd1);
    endtask

    int  cyc;
    int  run_cyc;
    bit  found;

    initial begin
        reset    = 1'b1;
        io_ready = 1'b0;
        msg_en   = {CT, CT};
        key      = KEY;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_msg_de", 256'(msg_de), 256'd0);
        check("rst_flags", 256'({aes_ready, aes_error, core_run}), 256'd0);
        check("rst_idx", 256'(block_idx), 256'd0);
        check("rst_core_key", 256'(core_key), 256'(KEY));
        $display("reset state checked");
        @(negedge clk);
        reset = 1'b0;

        // Known-answer decryption of two identical blocks
        @(negedge clk);
        msg_en   = {CT, CT};
        io_ready = 1'b1;
        wait_done("kat", cyc, run_cyc);
        check("kat_latency", 256'(cyc - 1), 256'd14);
        check("kat_msg_de", 256'(msg_de), {PT, PT});
        check("kat_error", 256'(aes_error), 256'd0);
        repeat (3) @(posedge clk);
        #1;
        check("kat_hold", 256'({aes_ready, msg_de}), {1'b1, PT, PT});
        $display("known-answer run: latency %0d", cyc - 1);

        // Re-arm: io_ready 1->0->1, second run with a distinct block 1
        @(negedge clk);
        io_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rearm_low", 256'(aes_ready), 256'd0);
        @(negedge clk);
        msg_en   = {B1, CT};
        io_ready = 1'b1;
        wait_done("rearm", cyc, run_cyc);
        check("rearm_latency", 256'(cyc - 1), 256'd14);
        check("rearm_msg_de", 256'(msg_de), {B1 ^ KEY, PT});
        $display("re-arm run: latency %0d", cyc - 1);

        // Core never answers: timeout on block 0
        do_reset();
        ready_delay = 0;
        msg_en      = {CT, CT};
        io_ready    = 1'b1;
        wait_done("to0", cyc, run_cyc);
        check("to0_compute_cycles", 256'(run_cyc), 256'd16);
        check("to0_flags", 256'({aes_error, aes_ready, core_run}), 256'b100);
        check("to0_msg_de", 256'(msg_de), 256'd0);
        @(negedge clk);
        io_ready = 1'b0;
        @(posedge clk);
        #1;
        check("to0_clear", 256'(aes_error), 256'd0);
        $display("timeout on block 0: %0d compute cycles", run_cyc);

        // Block 1 hangs after block 0 completes
        do_reset();
        ready_delay = 5;
        hang_blk    = 1;
        io_ready    = 1'b1;
        wait_done("to1", cyc, run_cyc);
        check("to1_latency", 256'(cyc - 1), 256'd24);
        check("to1_msg_de", 256'(msg_de), {128'd0, PT});
        check("to1_state", 256'({aes_error, aes_ready, block_idx}), {1'b1, 1'b0, 4'd1});
        $display("timeout on block 1 after %0d cycles", cyc - 1);

        // core_ready on the last budgeted cycle wins; io_ready drop mid-run ignored
        do_reset();
        hang_blk    = -1;
        ready_delay = 16;
        io_ready    = 1'b1;
        repeat (4) @(negedge clk);
        io_ready = 1'b0;
        wait_done("edge", cyc, run_cyc);
        check("edge_latency", 256'(cyc + 3), 256'd36);
        check("edge_flags", 256'({aes_ready, aes_error}), 256'b10);
        check("edge_msg_de", 256'(msg_de), {PT, PT});
        @(posedge clk);
        #1;
        check("edge_back_wait", 256'(aes_ready), 256'd0);
        $display("boundary completion: latency %0d", cyc + 3);

        // Reset in the middle of block 1 COMPUTE
        do_reset();
        ready_delay = 5;
        io_ready    = 1'b1;
        found       = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (block_idx == 4'd1 && core_run) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reach_blk1", 256'(found), 256'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        io_ready = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_msg_de", 256'(msg_de), 256'd0);
        check("mid_rst_flags", 256'({aes_ready, aes_error, core_run, block_idx}), 256'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_quiet", 256'({aes_ready, aes_error, core_run, msg_de}), 256'd0);
        $display("mid-compute reset checked");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
